// File: rtl/rs_bypass_pkg.sv
// Shared constants and helpers for the multi-port rs bypass network.
package rs_bypass_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int SEL_REGFILE = 0;

    // Select code k+1 names stage k, so one extra code is needed for the regfile.
    function automatic int sel_width(input int num_stg);
        return $clog2(num_stg + 1);
    endfunction

endpackage

// File: rtl/rs_bypass_match.sv
// Per-port priority matcher: the youngest valid entry whose rd equals the
// requested (non-x0) address wins; otherwise the regfile value passes through.
module rs_bypass_match
    import rs_bypass_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_STG = 3,
    parameter int SELW    = 2
) (
    input  logic [REG_ADDR_W-1:0]         addr_i,
    input  logic [XLEN-1:0]               rf_i,
    input  logic [NUM_STG-1:0]            ent_valid_i,
    input  logic [NUM_STG*REG_ADDR_W-1:0] ent_rd_i,
    input  logic [NUM_STG*XLEN-1:0]       ent_data_i,
    input  logic [NUM_STG-1:0]            ent_ready_i,
    output logic [SELW-1:0]               sel_o,
    output logic [XLEN-1:0]               data_o,
    output logic                          pending_o
);

    logic [NUM_STG-1:0] hit_s;

    // Scan oldest to youngest so the youngest hit overwrites the result last.
    always_comb begin
        sel_o     = SELW'(SEL_REGFILE);
        data_o    = rf_i;
        pending_o = 1'b0;
        hit_s     = '0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            hit_s[k]  = ent_valid_i[k] && (addr_i != '0) &&
                        (ent_rd_i[k*REG_ADDR_W +: REG_ADDR_W] == addr_i);
            sel_o     = hit_s[k] ? SELW'(k + 1) : sel_o;
            data_o    = hit_s[k] ? ent_data_i[k*XLEN +: XLEN] : data_o;
            pending_o = hit_s[k] ? ~ent_ready_i[k] : pending_o;
        end
    end

endmodule

// File: rtl/rs_bypass_unit.sv
// Forwarding network: tracks in-flight destination writes, resolves NUM_SRC
// source operands with youngest-stage priority and flags load-use stalls.
module rs_bypass_unit
    import rs_bypass_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NUM_SRC  = 2,
    parameter int NUM_STG  = 3,
    parameter int FILL_STG = 1,
    localparam int SELW    = sel_width(NUM_STG)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_advance,
    input  logic                          io_flush,
    input  logic                          io_wb_valid,
    input  logic [REG_ADDR_W-1:0]         io_wb_rd,
    input  logic [XLEN-1:0]               io_wb_data,
    input  logic                          io_wb_ready,
    input  logic                          io_ld_fill_valid,
    input  logic [XLEN-1:0]               io_ld_fill_data,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] io_rs_addr,
    input  logic [NUM_SRC*XLEN-1:0]       io_rs,
    output logic [NUM_SRC*XLEN-1:0]       io_to_rs_mux,
    output logic [NUM_SRC*SELW-1:0]       io_rs_bypass_mux_sel,
    output logic                          io_stall
);

    logic [NUM_STG-1:0]            valid_q, valid_d, ready_q, ready_d, eff_ready_s;
    logic [NUM_STG*REG_ADDR_W-1:0] rd_q, rd_d;
    logic [NUM_STG*XLEN-1:0]       data_q, data_d, eff_data_s;
    logic                          fill_hit_s;
    logic [NUM_SRC-1:0]            pend_s;
    logic [NUM_SRC*XLEN-1:0]       win_data_s, out_q;
    logic [NUM_SRC*SELW-1:0]       win_sel_s, sel_q;

    assign fill_hit_s = io_ld_fill_valid & valid_q[FILL_STG] & ~ready_q[FILL_STG];

    // Entry view with late load data merged in, so matching sees a same-cycle fill.
    always_comb begin
        eff_data_s  = data_q;
        eff_ready_s = ready_q;
        if (fill_hit_s) begin
            eff_data_s[FILL_STG*XLEN +: XLEN] = io_ld_fill_data;
            eff_ready_s[FILL_STG]             = 1'b1;
        end else begin
            eff_ready_s[FILL_STG] = ready_q[FILL_STG];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        rs_bypass_match #(
            .XLEN    (XLEN),
            .NUM_STG (NUM_STG),
            .SELW    (SELW)
        ) u_match (
            .addr_i      (io_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .rf_i        (io_rs[i*XLEN +: XLEN]),
            .ent_valid_i (valid_q),
            .ent_rd_i    (rd_q),
            .ent_data_i  (eff_data_s),
            .ent_ready_i (eff_ready_s),
            .sel_o       (win_sel_s[i*SELW +: SELW]),
            .data_o      (win_data_s[i*XLEN +: XLEN]),
            .pending_o   (pend_s[i])
        );
    end

    assign io_stall = |pend_s;

    // Shift on advance (stalled cycles inject a bubble at stage 0); otherwise hold.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = eff_data_s;
        ready_d = eff_ready_s;
        if (io_advance) begin
            for (int k = 1; k < NUM_STG; k++) begin
                valid_d[k]                          = valid_q[k-1];
                rd_d[k*REG_ADDR_W +: REG_ADDR_W]    = rd_q[(k-1)*REG_ADDR_W +: REG_ADDR_W];
                data_d[k*XLEN +: XLEN]              = eff_data_s[(k-1)*XLEN +: XLEN];
                ready_d[k]                          = eff_ready_s[k-1];
            end
            valid_d[0]              = io_wb_valid & ~io_flush & ~io_stall;
            rd_d[REG_ADDR_W-1:0]    = io_wb_rd;
            data_d[XLEN-1:0]        = io_wb_data;
            ready_d[0]              = io_wb_ready;
        end else begin
            valid_d[0] = valid_q[0] & ~io_flush;
        end
    end

    // Entry shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ready_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // Operand output registers update only when the pipeline actually moves.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            sel_q <= '0;
        end else if (io_advance && !io_stall) begin
            out_q <= win_data_s;
            sel_q <= win_sel_s;
        end else begin
            out_q <= out_q;
            sel_q <= sel_q;
        end
    end

    assign io_to_rs_mux         = out_q;
    assign io_rs_bypass_mux_sel = sel_q;

endmodule

// File: tb/tb_rs_bypass_unit.sv
// Scoreboard bench for rs_bypass_unit: default 2-port/3-stage instance plus a
// 3-port/4-stage instance; expectations are queued by cycle and checked at negedge.
module tb_rs_bypass_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Instance A: defaults
    logic        a_adv = 1'b0, a_flush = 1'b0, a_wbv = 1'b0, a_wbrdy = 1'b0, a_fv = 1'b0;
    logic [4:0]  a_wbrd = 5'd0;
    logic [31:0] a_wbdata = 32'd0, a_fdata = 32'd0;
    logic [9:0]  a_rsaddr = 10'd0;
    logic [63:0] a_rs = 64'd0;
    logic [63:0] a_out;
    logic [3:0]  a_sel;
    logic        a_stall;

    // Instance B: NUM_SRC=3, NUM_STG=4
    logic        b_adv = 1'b0, b_flush = 1'b0, b_wbv = 1'b0, b_wbrdy = 1'b0, b_fv = 1'b0;
    logic [4:0]  b_wbrd = 5'd0;
    logic [31:0] b_wbdata = 32'd0, b_fdata = 32'd0;
    logic [14:0] b_rsaddr = 15'd0;
    logic [95:0] b_rs = 96'd0;
    logic [95:0] b_out;
    logic [8:0]  b_sel;
    logic        b_stall;

    rs_bypass_unit u_dut_a (
        .clock(clock), .reset(reset), .io_advance(a_adv), .io_flush(a_flush),
        .io_wb_valid(a_wbv), .io_wb_rd(a_wbrd), .io_wb_data(a_wbdata), .io_wb_ready(a_wbrdy),
        .io_ld_fill_valid(a_fv), .io_ld_fill_data(a_fdata), .io_rs_addr(a_rsaddr), .io_rs(a_rs),
        .io_to_rs_mux(a_out), .io_rs_bypass_mux_sel(a_sel), .io_stall(a_stall)
    );

    rs_bypass_unit #(.NUM_SRC(3), .NUM_STG(4)) u_dut_b (
        .clock(clock), .reset(reset), .io_advance(b_adv), .io_flush(b_flush),
        .io_wb_valid(b_wbv), .io_wb_rd(b_wbrd), .io_wb_data(b_wbdata), .io_wb_ready(b_wbrdy),
        .io_ld_fill_valid(b_fv), .io_ld_fill_data(b_fdata), .io_rs_addr(b_rsaddr), .io_rs(b_rs),
        .io_to_rs_mux(b_out), .io_rs_bypass_mux_sel(b_sel), .io_stall(b_stall)
    );

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;   // 0 data, 1 sel, 2 stall
        int          port;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    string label = "init";

    function automatic logic [31:0] actual(input int d, input int k, input int p);
        if (d == 0) begin
            case (k)
                0:       return a_out[p*32 +: 32];
                1:       return 32'(a_sel[p*2 +: 2]);
                default: return 32'(a_stall);
            endcase
        end else begin
            case (k)
                0:       return b_out[p*32 +: 32];
                1:       return 32'(b_sel[p*3 +: 3]);
                default: return 32'(b_stall);
            endcase
        end
    endfunction

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clock) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                logic [31:0] act;
                act = actual(sbq[i].dut, sbq[i].kind, sbq[i].port);
                n_checks++;
                if (act !== sbq[i].val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             sbq[i].nm, act, sbq[i].val, cyc);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic push(input int tag, input int d, input int k, input int p,
                        input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = tag; e.dut = d; e.kind = k; e.port = p; e.val = v;
        e.nm = $sformatf("%s.%s%0d", label, nm, p);
        sbq.push_back(e);
    endtask

    // Registered outputs: visible one cycle after the current inputs
    task automatic exp_port(input int d, input int p, input logic [31:0] v, input int s);
        push(cyc + 1, d, 0, p, v, (d == 0) ? "A.data" : "B.data");
        push(cyc + 1, d, 1, p, 32'(s), (d == 0) ? "A.sel" : "B.sel");
    endtask

    task automatic exp_port_now(input int d, input int p, input logic [31:0] v, input int s);
        push(cyc, d, 0, p, v, (d == 0) ? "A.data" : "B.data");
        push(cyc, d, 1, p, 32'(s), (d == 0) ? "A.sel" : "B.sel");
    endtask

    task automatic exp_stall(input int d, input logic v);
        push(cyc, d, 2, 0, {31'd0, v}, (d == 0) ? "A.stall" : "B.stall");
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_wr(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic rdy);
        a_wbv = v; a_wbrd = rd; a_wbdata = d; a_wbrdy = rdy;
    endtask

    task automatic a_rd(input logic [4:0] p0, input logic [4:0] p1);
        a_rsaddr = {p1, p0};
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (a_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset.A.out: got 0x%016h", a_out);
        end
        n_checks++;
        if (a_sel !== 4'd0) begin
            n_fail++;
            $display("FAIL reset.A.sel: got 0x%0h", a_sel);
        end
        n_checks++;
        if (a_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset.A.stall: got %b", a_stall);
        end
        n_checks++;
        if (b_out !== 96'd0) begin
            n_fail++;
            $display("FAIL reset.B.out: got 0x%024h", b_out);
        end
        n_checks++;
        if (b_sel !== 9'd0) begin
            n_fail++;
            $display("FAIL reset.B.sel: got 0x%0h", b_sel);
        end
        label = "reset";
        exp_port_now(0, 0, 32'd0, 0);
        exp_port_now(0, 1, 32'd0, 0);
        exp_stall(0, 1'b0);
        reset = 1'b1;

        // EX forwarding
        step(); label = "fwd_wr";
        a_wr(1'b1, 5'd5, 32'hAAAA0001, 1'b1); a_adv = 1'b1; a_rd(5'd0, 5'd0);
        a_rs = {32'h2000_0000, 32'h1000_0000};
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'h1000_0000, 0); exp_port(0, 1, 32'h2000_0000, 0);
        step(); label = "fwd_ex";
        a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_rd(5'd5, 5'd0);
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'hAAAA0001, 1); exp_port(0, 1, 32'h2000_0000, 0);

        // Priority: stage0 x7=2 over stage1 x7=1
        step(); label = "prio_w1";
        a_wr(1'b1, 5'd7, 32'h1, 1'b1); a_rd(5'd0, 5'd0);
        exp_port(0, 0, 32'h1000_0000, 0); exp_port(0, 1, 32'h2000_0000, 0);
        step();
        a_wr(1'b1, 5'd7, 32'h2, 1'b1);
        step(); label = "prio";
        a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_rd(5'd7, 5'd7);
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'h2, 1); exp_port(0, 1, 32'h2, 1);
        step(); label = "prio_s2";
        a_wr(1'b1, 5'd0, 32'h55, 1'b1); a_rd(5'd7, 5'd7);
        exp_port(0, 0, 32'h2, 2); exp_port(0, 1, 32'h2, 2);
        step(); label = "x0";
        a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_rd(5'd0, 5'd0);
        exp_port(0, 0, 32'h1000_0000, 0); exp_port(0, 1, 32'h2000_0000, 0);

        // Load-use
        step(); label = "ld_issue";
        a_wr(1'b1, 5'd9, 32'd0, 1'b0); a_rd(5'd0, 5'd0);
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'h1000_0000, 0); exp_port(0, 1, 32'h2000_0000, 0);
        step(); label = "ld_stall";
        a_wr(1'b1, 5'd12, 32'hC, 1'b1); a_rd(5'd0, 5'd9);
        a_rs = {32'h2000_0009, 32'h1000_0009};
        exp_stall(0, 1'b1);
        exp_port(0, 0, 32'h1000_0000, 0); exp_port(0, 1, 32'h2000_0000, 0);
        step(); label = "ld_fill";
        a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_fv = 1'b1; a_fdata = 32'hDEADBEEF;
        a_rd(5'd12, 5'd9);
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'h1000_0009, 0); exp_port(0, 1, 32'hDEADBEEF, 2);
        step(); label = "ld_after";
        a_fv = 1'b0; a_rd(5'd9, 5'd0);
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'hDEADBEEF, 3); exp_port(0, 1, 32'h2000_0009, 0);

        // Hold
        step(); label = "hold_wr";
        a_wr(1'b1, 5'd3, 32'h33, 1'b1); a_rd(5'd0, 5'd0);
        exp_port(0, 0, 32'h1000_0009, 0); exp_port(0, 1, 32'h2000_0009, 0);
        for (int i = 0; i < 3; i++) begin
            step(); label = "hold";
            a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_adv = 1'b0; a_rd(5'd3, 5'd3);
            a_rs = {32'h2000_000F, 32'h1000_000F};
            exp_stall(0, 1'b0);
            exp_port(0, 0, 32'h1000_0009, 0); exp_port(0, 1, 32'h2000_0009, 0);
        end
        step(); label = "hold_rel";
        a_adv = 1'b1; a_rd(5'd3, 5'd0);
        exp_port(0, 0, 32'h33, 1); exp_port(0, 1, 32'h2000_000F, 0);

        // Flush with advance, then flush while holding
        step(); label = "flush_adv";
        a_flush = 1'b1; a_wr(1'b1, 5'd4, 32'h44, 1'b1); a_rd(5'd3, 5'd4);
        exp_port(0, 0, 32'h33, 2); exp_port(0, 1, 32'h2000_000F, 0);
        step(); label = "flush_chk";
        a_flush = 1'b0; a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_rd(5'd3, 5'd4);
        exp_port(0, 0, 32'h33, 3); exp_port(0, 1, 32'h2000_000F, 0);
        step(); label = "fh_wr";
        a_wr(1'b1, 5'd6, 32'h66, 1'b1); a_rd(5'd0, 5'd0);
        exp_port(0, 0, 32'h1000_000F, 0); exp_port(0, 1, 32'h2000_000F, 0);
        step(); label = "flush_hold";
        a_adv = 1'b0; a_flush = 1'b1; a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_rd(5'd6, 5'd6);
        a_rs = {32'h2000_0010, 32'h1000_0010};
        exp_port(0, 0, 32'h1000_000F, 0); exp_port(0, 1, 32'h2000_000F, 0);
        step(); label = "flush_hchk";
        a_adv = 1'b1; a_flush = 1'b0;
        exp_port(0, 0, 32'h1000_0010, 0); exp_port(0, 1, 32'h2000_0010, 0);

        // Reset mid-run with a pending load in flight
        step(); label = "mid_ld";
        a_wr(1'b1, 5'd5, 32'h77, 1'b0); a_rd(5'd0, 5'd0);
        step(); label = "mid_rst";
        reset = 1'b0;
        a_wr(1'b0, 5'd0, 32'd0, 1'b0); a_adv = 1'b0; a_rd(5'd5, 5'd5);
        exp_port_now(0, 0, 32'd0, 0); exp_port_now(0, 1, 32'd0, 0);
        exp_stall(0, 1'b0);
        step(); label = "post_rst";
        reset = 1'b1; a_adv = 1'b1; a_rd(5'd5, 5'd0);
        a_rs = {32'h2000_0000, 32'h0000_1111};
        exp_stall(0, 1'b0);
        exp_port(0, 0, 32'h0000_1111, 0); exp_port(0, 1, 32'h2000_0000, 0);
        step();
        a_adv = 1'b0;

        // Instance B: deep stage forwards with sel 4, then is discarded
        b_rs = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};
        step(); label = "b_wr";
        b_wbv = 1'b1; b_wbrd = 5'd10; b_wbdata = 32'h0000_B0B0; b_wbrdy = 1'b1; b_adv = 1'b1;
        b_rsaddr = 15'd0;
        exp_port(1, 2, 32'h3000_0000, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            b_wbv = 1'b0;
        end
        step(); label = "b_stg3";
        b_rsaddr = {5'd10, 5'd0, 5'd0};
        exp_stall(1, 1'b0);
        exp_port(1, 0, 32'h1000_0000, 0); exp_port(1, 1, 32'h2000_0000, 0);
        exp_port(1, 2, 32'h0000_B0B0, 4);
        step(); label = "b_gone";
        exp_port(1, 0, 32'h1000_0000, 0); exp_port(1, 1, 32'h2000_0000, 0);
        exp_port(1, 2, 32'h3000_0000, 0);
        step();
        b_adv = 1'b0;
        repeat (3) step();

        while (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, expected 0x%08h", sbq[0].nm, sbq[0].val);
            void'(sbq.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
